// File: rtl/activation_pipe_pkg.sv
// Shared definitions for the activation/requantisation pipeline: accumulator
// and output widths, activation mode encodings, and the per-beat control
// bundle that travels alongside the data.
// Optional feature macro: ACT_LEAKY_EN (enables the leaky ReLU datapath).
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACT_RELU
`define ACT_RELU 2'b00
`endif
`ifndef ACT_STEP
`define ACT_STEP 2'b01
`endif
`ifndef ACT_LINEAR
`define ACT_LINEAR 2'b10
`endif
`ifndef ACT_LEAKY
`define ACT_LEAKY 2'b11
`endif

package activation_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_RELU   = `ACT_RELU,
    MODE_STEP   = `ACT_STEP,
    MODE_LINEAR = `ACT_LINEAR,
    MODE_LEAKY  = `ACT_LEAKY
  } act_mode_e;

  localparam int LEAK_SHIFT_W = 3;
  localparam int SAT_CNT_W    = 16;

  // Control that rides with a beat through stage 1 so later config changes
  // never affect beats already in flight.
  typedef struct packed {
    act_mode_e                mode;
    logic [LEAK_SHIFT_W-1:0]  leak_shift;
    logic                     last;
  } beat_ctl_t;

endpackage

// File: rtl/activation_pipe_act_lane.sv
// act_lane: combinational stage-2 activation for one lane. Takes the rounded,
// ACC_WIDTH+1-bit value and produces the narrow signed result plus a flag
// saying whether the value had to be clamped.
// Optional feature macro: ACT_LEAKY_EN (mode 11 = leaky ReLU, else linear).
module act_lane
  import activation_pipe_pkg::*;
#(
  parameter int ACC_WIDTH      = `ACC_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int STEP_THRESHOLD = 0
) (
  input  logic signed [ACC_WIDTH:0]      r,
  input  act_mode_e                      mode,
  input  logic [LEAK_SHIFT_W-1:0]        leak_shift,
  output logic signed [DATA_WIDTH-1:0]   y,
  output logic                           clamped
);

  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [RW-1:0] THR  = RW'(STEP_THRESHOLD);

  logic signed [DATA_WIDTH-1:0] relu_y, lin_y, step_y;
  logic                         relu_c, lin_c;

`ifdef ACT_LEAKY_EN
  logic signed [RW-1:0]         neg;
  logic signed [DATA_WIDTH-1:0] leak_y;
  logic                         leak_c;
`else
  logic unused_leak;
  assign unused_leak = ^leak_shift;
`endif

  // candidate results for every mode, then pick by mode
  always_comb begin
    relu_y = '0;
    relu_c = 1'b0;
    if (r < 0) begin
      relu_y = '0;
    end else if (r > MAXV) begin
      relu_y = MAXV[DATA_WIDTH-1:0];
      relu_c = 1'b1;
    end else begin
      relu_y = r[DATA_WIDTH-1:0];
    end

    lin_y = r[DATA_WIDTH-1:0];
    lin_c = 1'b0;
    if (r > MAXV) begin
      lin_y = MAXV[DATA_WIDTH-1:0];
      lin_c = 1'b1;
    end else if (r < MINV) begin
      lin_y = MINV[DATA_WIDTH-1:0];
      lin_c = 1'b1;
    end

    // step is a threshold decision, so it is never a saturation event
    step_y = (r > THR) ? MAXV[DATA_WIDTH-1:0] : '0;

`ifdef ACT_LEAKY_EN
    // arithmetic shift floors; only the lower bound can be exceeded here
    neg    = r >>> leak_shift;
    leak_y = neg[DATA_WIDTH-1:0];
    leak_c = 1'b0;
    if (r >= 0) begin
      leak_y = relu_y;
      leak_c = relu_c;
    end else if (neg < MINV) begin
      leak_y = MINV[DATA_WIDTH-1:0];
      leak_c = 1'b1;
    end
`endif

    case (mode)
      MODE_RELU: begin y = relu_y; clamped = relu_c; end
      MODE_STEP: begin y = step_y; clamped = 1'b0;   end
`ifdef ACT_LEAKY_EN
      MODE_LEAKY: begin y = leak_y; clamped = leak_c; end
`endif
      default:   begin y = lin_y;  clamped = lin_c;  end
    endcase
  end

endmodule

// File: rtl/activation_pipe.sv
// activation_pipe: two-stage, LANES-wide requantisation and activation.
// Stage 1 applies a rounding right-shift (round half toward +inf) in
// ACC_WIDTH+1 bits; stage 2 applies the activation per lane and registers
// the narrow result. Full valid/ready backpressure, plus a saturating count
// of output beats that contained a clamped lane.
// Optional feature macro: ACT_LEAKY_EN (mode 11 = leaky ReLU, else linear).
module activation_pipe
  import activation_pipe_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int ACC_WIDTH      = `ACC_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int SHIFT_WIDTH    = 5,
  parameter int STEP_THRESHOLD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    cfg_mode,
  input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
  input  logic [2:0]                    cfg_leak_shift,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*ACC_WIDTH-1:0]    in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic                          out_last,
  input  logic                          sat_clear,
  output logic [SAT_CNT_W-1:0]          sat_count,
  output logic                          busy
);

  localparam int RW     = ACC_WIDTH + 1;
  localparam int STAGES = 2;

  logic [STAGES:1]                      vld_pipe;
  logic                                 s2_adv;
  logic                                 s1_adv;
  logic                                 accept;

  logic [LANES-1:0][ACC_WIDTH-1:0]      in_lanes;
  logic [LANES-1:0][RW-1:0]             rnd;
  logic [LANES-1:0][RW-1:0]             s1_r;
  beat_ctl_t                            s1_ctl;
  beat_ctl_t                            in_ctl;

  logic [LANES-1:0][DATA_WIDTH-1:0]     act_y;
  logic [LANES-1:0]                     act_c;
  logic [LANES-1:0][DATA_WIDTH-1:0]     s2_data;
  logic                                 s2_last;
  logic                                 s2_sat;
  logic                                 sat_inc;

  assign in_lanes = in_data;

  // handshake: the output stage frees up when empty or being drained, and
  // stage 1 can take a new beat when it is empty or moving into stage 2
  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign s1_adv   = vld_pipe[1] && s2_adv;
  assign in_ready = rst_n && (!vld_pipe[1] || s2_adv);
  assign accept   = in_valid && in_ready;

  assign in_ctl.mode = act_mode_e'(cfg_mode);
  assign in_ctl.last = in_last;
`ifdef ACT_LEAKY_EN
  assign in_ctl.leak_shift = cfg_leak_shift;
`else
  logic unused_cfg_leak;
  assign unused_cfg_leak   = ^cfg_leak_shift;
  assign in_ctl.leak_shift = '0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [RW-1:0] xe;
    logic signed [RW-1:0] bias;

    // one extra bit of headroom so adding the rounding bias never wraps
    assign xe     = {in_lanes[i][ACC_WIDTH-1], in_lanes[i]};
    assign bias   = (cfg_shift == '0) ? '0 : (RW'(1) << (cfg_shift - SHIFT_WIDTH'(1)));
    assign rnd[i] = (xe + bias) >>> cfg_shift;

    act_lane #(
      .ACC_WIDTH      (ACC_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .STEP_THRESHOLD (STEP_THRESHOLD)
    ) u_act (
      .r          (s1_r[i]),
      .mode       (s1_ctl.mode),
      .leak_shift (s1_ctl.leak_shift),
      .y          (act_y[i]),
      .clamped    (act_c[i])
    );
  end

  // valid shift register: each stage takes its upstream valid when free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_adv)   vld_pipe[2] <= vld_pipe[1];
    end
  end

  // stage 1 data: rounded lanes plus the config sampled with the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r   <= '0;
      s1_ctl <= '0;
    end else if (accept) begin
      s1_r   <= rnd;
      s1_ctl <= in_ctl;
    end
  end

  // stage 2 data: only loads on a real transfer so it holds during stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_data <= '0;
      s2_last <= 1'b0;
      s2_sat  <= 1'b0;
    end else if (s1_adv) begin
      s2_data <= act_y;
      s2_last <= s1_ctl.last;
      s2_sat  <= |act_c;
    end
  end

  assign sat_inc = vld_pipe[2] && out_ready && s2_sat;

  // saturating debug counter; clear has priority over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (sat_inc && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_data  = s2_data;
  assign out_last  = s2_last;
  assign busy      = |vld_pipe;

endmodule
